// File: rtl/tlb_op_unit.sv
// tlb_op_unit: runs one TLB command (search, read, write, fill or invalidate)
// using a snapshot of the CSR inputs. Every command goes IDLE -> EXEC -> RESP.
// During EXEC the unit drives the TLB-side ports and pulses the write or
// invalidate strobe. In RESP it holds the result until the consumer takes it.
module tlb_op_unit #(
    parameter int TLBNUM = 16,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    // command handshake and operands
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_inv_op,
    input  logic [9:0]    req_inv_asid,
    input  logic [18:0]   req_inv_vppn,
    // CSR snapshot, elo = {ppn[19:0], g, mat[1:0], plv[1:0], d, v}
    input  logic [IW-1:0] csr_idx,
    input  logic [5:0]    csr_ps,
    input  logic          csr_ne,
    input  logic [18:0]   csr_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [26:0]   csr_elo0,
    input  logic [26:0]   csr_elo1,
    // TLB write port
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic          tlb_w_e,
    output logic [18:0]   tlb_w_vppn,
    output logic [5:0]    tlb_w_ps,
    output logic [9:0]    tlb_w_asid,
    output logic          tlb_w_g,
    output logic [25:0]   tlb_w_lo0,
    output logic [25:0]   tlb_w_lo1,
    // TLB search / read / invalidate ports
    output logic [18:0]   tlb_s_vppn,
    output logic [9:0]    tlb_s_asid,
    output logic [IW-1:0] tlb_r_index,
    output logic          tlb_inv_valid,
    output logic [4:0]    tlb_inv_op,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,
    input  logic          tlb_r_e,
    input  logic [18:0]   tlb_r_vppn,
    input  logic [5:0]    tlb_r_ps,
    input  logic [9:0]    tlb_r_asid,
    input  logic          tlb_r_g,
    input  logic [25:0]   tlb_r_lo0,
    input  logic [25:0]   tlb_r_lo1,
    // response
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_err,
    output logic [2:0]    resp_op,
    output logic [IW-1:0] resp_idx,
    output logic          resp_ne,
    output logic [5:0]    resp_ps,
    output logic [18:0]   resp_vppn,
    output logic [9:0]    resp_asid,
    output logic [26:0]   resp_elo0,
    output logic [26:0]   resp_elo1
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t        state;
    logic [IW-1:0] fill_ptr;

    // command snapshot taken at acceptance
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vppn_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] fptr_q;
    logic [5:0]    ps_q;
    logic [18:0]   vppn_q;
    logic [9:0]    asid_q;
    logic [26:0]   elo0_q;
    logic [26:0]   elo1_q;
    logic          w_e_q;
    logic          w_g_q;

    // TLB ports come straight from the snapshot, so they stay steady for the whole EXEC cycle
    assign tlb_w_index = (op_q == OP_FILL) ? fptr_q : idx_q;
    assign tlb_w_e     = w_e_q;
    assign tlb_w_g     = w_g_q;
    assign tlb_w_vppn  = vppn_q;
    assign tlb_w_ps    = ps_q;
    assign tlb_w_asid  = asid_q;
    assign tlb_w_lo0   = {elo0_q[26:7], elo0_q[5:0]};
    assign tlb_w_lo1   = {elo1_q[26:7], elo1_q[5:0]};
    assign tlb_s_vppn  = (op_q == OP_INV) ? inv_vppn_q : vppn_q;
    assign tlb_s_asid  = (op_q == OP_INV) ? inv_asid_q : asid_q;
    assign tlb_r_index = idx_q;
    assign tlb_inv_op  = inv_op_q;

    // Command FSM. The strobes and the response are registered here. Reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            fill_ptr      <= '0;
            req_ready     <= 1'b1;
            tlb_we        <= 1'b0;
            tlb_inv_valid <= 1'b0;
            op_q          <= '0;
            inv_op_q      <= '0;
            inv_asid_q    <= '0;
            inv_vppn_q    <= '0;
            idx_q         <= '0;
            fptr_q        <= '0;
            ps_q          <= '0;
            vppn_q        <= '0;
            asid_q        <= '0;
            elo0_q        <= '0;
            elo1_q        <= '0;
            w_e_q         <= 1'b0;
            w_g_q         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_op       <= '0;
            resp_idx      <= '0;
            resp_ne       <= 1'b0;
            resp_ps       <= '0;
            resp_vppn     <= '0;
            resp_asid     <= '0;
            resp_elo0     <= '0;
            resp_elo1     <= '0;
        end else begin
            // the round-robin fill pointer runs freely, whatever the FSM is doing
            fill_ptr <= (fill_ptr == IW'(TLBNUM - 1)) ? '0 : fill_ptr + 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q          <= req_op;
                        inv_op_q      <= req_inv_op;
                        inv_asid_q    <= req_inv_asid;
                        inv_vppn_q    <= req_inv_vppn;
                        idx_q         <= csr_idx;
                        fptr_q        <= fill_ptr;
                        ps_q          <= csr_ps;
                        vppn_q        <= csr_vppn;
                        asid_q        <= csr_asid;
                        elo0_q        <= csr_elo0;
                        elo1_q        <= csr_elo1;
                        w_e_q         <= ~csr_ne;
                        w_g_q         <= csr_elo0[6] & csr_elo1[6];
                        tlb_we        <= (req_op == OP_WR) || (req_op == OP_FILL);
                        tlb_inv_valid <= (req_op == OP_INV) && (req_inv_op <= 5'd6);
                        req_ready     <= 1'b0;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    tlb_we        <= 1'b0;
                    tlb_inv_valid <= 1'b0;
                    resp_valid    <= 1'b1;
                    resp_op       <= op_q;
                    resp_err      <= 1'b0;
                    resp_idx      <= '0;
                    resp_ne       <= 1'b0;
                    resp_ps       <= '0;
                    resp_vppn     <= '0;
                    resp_asid     <= '0;
                    resp_elo0     <= '0;
                    resp_elo1     <= '0;
                    case (op_q)
                        OP_SRCH: begin
                            resp_idx <= tlb_s_found ? tlb_s_index : idx_q;
                            resp_ne  <= ~tlb_s_found;
                        end
                        OP_RD: begin
                            resp_idx <= idx_q;
                            resp_ne  <= ~tlb_r_e;
                            // an invalid entry reads back as all-zero data
                            if (tlb_r_e) begin
                                resp_ps   <= tlb_r_ps;
                                resp_vppn <= tlb_r_vppn;
                                resp_asid <= tlb_r_asid;
                                resp_elo0 <= {tlb_r_lo0[25:6], tlb_r_g, tlb_r_lo0[5:0]};
                                resp_elo1 <= {tlb_r_lo1[25:6], tlb_r_g, tlb_r_lo1[5:0]};
                            end
                        end
                        OP_WR, OP_FILL: resp_idx <= tlb_w_index;
                        OP_INV:         resp_err <= (inv_op_q > 5'd6);
                        default:        resp_err <= 1'b1;
                    endcase
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Self-checking bench for tlb_op_unit: directed scenarios plus a randomized
// sweep compared against expectations derived from the command rules.
module tb_tlb_op_unit;
    localparam int TLBNUM = 16;
    localparam int IW = 4;

    logic          clk, resetn;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [9:0]    req_inv_asid;
    logic [18:0]   req_inv_vppn;
    logic [IW-1:0] csr_idx;
    logic [5:0]    csr_ps;
    logic          csr_ne;
    logic [18:0]   csr_vppn;
    logic [9:0]    csr_asid;
    logic [26:0]   csr_elo0, csr_elo1;
    logic          tlb_we, tlb_w_e, tlb_w_g;
    logic [IW-1:0] tlb_w_index;
    logic [18:0]   tlb_w_vppn;
    logic [5:0]    tlb_w_ps;
    logic [9:0]    tlb_w_asid;
    logic [25:0]   tlb_w_lo0, tlb_w_lo1;
    logic [18:0]   tlb_s_vppn;
    logic [9:0]    tlb_s_asid;
    logic [IW-1:0] tlb_r_index;
    logic          tlb_inv_valid;
    logic [4:0]    tlb_inv_op;
    logic          tlb_s_found;
    logic [IW-1:0] tlb_s_index;
    logic          tlb_r_e, tlb_r_g;
    logic [18:0]   tlb_r_vppn;
    logic [5:0]    tlb_r_ps;
    logic [9:0]    tlb_r_asid;
    logic [25:0]   tlb_r_lo0, tlb_r_lo1;
    logic          resp_valid, resp_ready, resp_err, resp_ne;
    logic [2:0]    resp_op;
    logic [IW-1:0] resp_idx;
    logic [5:0]    resp_ps;
    logic [18:0]   resp_vppn;
    logic [9:0]    resp_asid;
    logic [26:0]   resp_elo0, resp_elo1;

    int passed = 0;
    int total  = 0;
    int m_fp   = 0;   // expected fill pointer: cycles since reset, modulo TLBNUM
    int fp_at  = 0;   // fill pointer value in the acceptance cycle

    tlb_op_unit #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
        .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn),
        .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
        .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid), .tlb_r_index(tlb_r_index),
        .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index), .tlb_r_e(tlb_r_e),
        .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
        .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err), .resp_op(resp_op),
        .resp_idx(resp_idx), .resp_ne(resp_ne), .resp_ps(resp_ps), .resp_vppn(resp_vppn),
        .resp_asid(resp_asid), .resp_elo0(resp_elo0), .resp_elo1(resp_elo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) m_fp <= resetn ? (m_fp + 1) % TLBNUM : 0;

    function automatic logic [25:0] strip_g(input logic [26:0] elo);
        return 26'((elo >> 7) << 6) | 26'(elo & 27'h3f);
    endfunction

    function automatic logic [26:0] add_g(input logic [25:0] lo, input logic g);
        return 27'((27'(lo) >> 6) << 7) | (27'(g) << 6) | 27'(lo & 26'h3f);
    endfunction

    task automatic scramble();
        csr_idx = IW'($urandom); csr_ps = 6'($urandom); csr_ne = 1'($urandom);
        csr_vppn = 19'($urandom); csr_asid = 10'($urandom);
        csr_elo0 = 27'($urandom); csr_elo1 = 27'($urandom);
        req_inv_op = 5'($urandom); req_inv_asid = 10'($urandom); req_inv_vppn = 19'($urandom);
    endtask

    // Present a command and wait for it to be accepted. Returns in the EXEC cycle,
    // just after the edge. The CSR inputs are then changed, so the command must
    // rely on its own snapshot.
    task automatic send(input logic [2:0] op);
        int w = 0;
        while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
        total++;
        if (!req_ready) $display("FAIL send_ready got=%0b exp=1", req_ready); else passed++;
        req_op = op; req_valid = 1'b1; fp_at = m_fp;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_op = '0; scramble();
        tlb_s_found = 0; tlb_s_index = 0; tlb_r_e = 0; tlb_r_g = 0; tlb_r_vppn = 0;
        tlb_r_ps = 0; tlb_r_asid = 0; tlb_r_lo0 = 0; tlb_r_lo1 = 0;
        repeat (3) @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got=%0b exp=1", req_ready); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); else passed++;
        total++; if (tlb_we !== 1'b0) $display("FAIL rst_we got=%0b exp=0", tlb_we); else passed++;
        total++; if (tlb_inv_valid !== 1'b0) $display("FAIL rst_inv got=%0b exp=0", tlb_inv_valid); else passed++;
        total++; if (tlb_w_e !== 1'b0) $display("FAIL rst_w_e got=%0b exp=0", tlb_w_e); else passed++;
        total++; if (resp_idx !== '0) $display("FAIL rst_resp_idx got=%0h exp=0", resp_idx); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_wr();
        logic [26:0] e0, e1;
        logic [18:0] v;
        e0 = 27'($urandom) | 27'h40; e1 = 27'($urandom) & ~27'h40; v = 19'($urandom);
        csr_idx = 5; csr_ne = 0; csr_elo0 = e0; csr_elo1 = e1; csr_vppn = v;
        send(3'd2);
        total++; if (tlb_we !== 1'b1) $display("FAIL wr_we got=%0b exp=1", tlb_we); else passed++;
        total++; if (tlb_w_index !== 4'd5) $display("FAIL wr_index got=%0d exp=5", tlb_w_index); else passed++;
        total++; if (tlb_w_e !== 1'b1) $display("FAIL wr_w_e got=%0b exp=1", tlb_w_e); else passed++;
        total++; if (tlb_w_g !== 1'b0) $display("FAIL wr_w_g got=%0b exp=0", tlb_w_g); else passed++;
        total++; if (tlb_w_vppn !== v) $display("FAIL wr_vppn got=%0h exp=%0h", tlb_w_vppn, v); else passed++;
        total++; if (tlb_w_lo0 !== strip_g(e0)) $display("FAIL wr_lo0 got=%0h exp=%0h", tlb_w_lo0, strip_g(e0)); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL wr_early_resp got=%0b exp=0", resp_valid); else passed++;
        step();
        total++; if (tlb_we !== 1'b0) $display("FAIL wr_we_pulse got=%0b exp=0", tlb_we); else passed++;
        total++; if (resp_valid !== 1'b1) $display("FAIL wr_resp_valid got=%0b exp=1", resp_valid); else passed++;
        total++; if (resp_idx !== 4'd5) $display("FAIL wr_resp_idx got=%0d exp=5", resp_idx); else passed++;
        drain();
    endtask

    task automatic test_srch();
        logic [9:0] a;
        for (int hit = 1; hit >= 0; hit--) begin
            a = 10'($urandom);
            csr_vppn = 19'h1234; csr_asid = a; csr_idx = 3;
            tlb_s_found = 1'(hit); tlb_s_index = 9;
            send(3'd0);
            total++; if (tlb_s_vppn !== 19'h1234) $display("FAIL srch_s_vppn got=%0h exp=1234", tlb_s_vppn); else passed++;
            total++; if (tlb_s_asid !== a) $display("FAIL srch_s_asid got=%0h exp=%0h", tlb_s_asid, a); else passed++;
            step();
            total++; if (resp_idx !== (hit ? 4'd9 : 4'd3)) $display("FAIL srch_idx hit=%0d got=%0d", hit, resp_idx); else passed++;
            total++; if (resp_ne !== 1'(!hit)) $display("FAIL srch_ne hit=%0d got=%0b", hit, resp_ne); else passed++;
            drain();
        end
    endtask

    task automatic test_rd();
        tlb_r_e = 0; tlb_r_g = 1; tlb_r_ps = 6'($urandom); tlb_r_vppn = 19'($urandom) | 19'h1;
        tlb_r_asid = 10'($urandom); tlb_r_lo0 = 26'($urandom) | 26'h1; tlb_r_lo1 = 26'($urandom) | 26'h1;
        csr_idx = 7;
        send(3'd1);
        total++; if (tlb_r_index !== 4'd7) $display("FAIL rd_r_index got=%0d exp=7", tlb_r_index); else passed++;
        step();
        total++; if (resp_ne !== 1'b1) $display("FAIL rd_miss_ne got=%0b exp=1", resp_ne); else passed++;
        total++;
        if ({resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1} !== '0)
            $display("FAIL rd_miss_zero got=%0h/%0h/%0h/%0h/%0h exp=0", resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1);
        else passed++;
        drain();
        tlb_r_e = 1;
        send(3'd1);
        step();
        total++; if (resp_ne !== 1'b0) $display("FAIL rd_hit_ne got=%0b exp=0", resp_ne); else passed++;
        total++; if ({resp_elo0[6], resp_elo1[6]} !== 2'b11) $display("FAIL rd_g got=%0b%0b exp=11", resp_elo0[6], resp_elo1[6]); else passed++;
        total++; if (resp_elo1 !== add_g(tlb_r_lo1, 1'b1)) $display("FAIL rd_elo1 got=%0h exp=%0h", resp_elo1, add_g(tlb_r_lo1, 1'b1)); else passed++;
        total++; if (resp_vppn !== tlb_r_vppn) $display("FAIL rd_vppn got=%0h exp=%0h", resp_vppn, tlb_r_vppn); else passed++;
        drain();
    endtask

    task automatic test_fill_wrap();
        int w = 0;
        while (m_fp != TLBNUM - 1 && w < 40) begin step(); w++; end
        send(3'd3);
        total++; if (tlb_w_index !== 4'd15) $display("FAIL fill15_index got=%0d exp=15", tlb_w_index); else passed++;
        step();
        total++; if (resp_idx !== 4'd15) $display("FAIL fill15_resp got=%0d exp=15", resp_idx); else passed++;
        drain();
        send(3'd3);
        total++; if (tlb_w_index !== IW'(fp_at)) $display("FAIL fill_next_index got=%0d exp=%0d", tlb_w_index, fp_at); else passed++;
        step(); drain();
    endtask

    task automatic test_inv();
        logic [18:0] v;
        v = 19'($urandom);
        req_inv_op = 5; req_inv_asid = 10'h2A; req_inv_vppn = v;
        send(3'd4);
        total++; if (tlb_inv_valid !== 1'b1) $display("FAIL inv5_valid got=%0b exp=1", tlb_inv_valid); else passed++;
        total++; if (tlb_s_asid !== 10'h2A) $display("FAIL inv5_asid got=%0h exp=2a", tlb_s_asid); else passed++;
        total++; if (tlb_s_vppn !== v) $display("FAIL inv5_vppn got=%0h exp=%0h", tlb_s_vppn, v); else passed++;
        total++; if (tlb_inv_op !== 5'd5) $display("FAIL inv5_op got=%0d exp=5", tlb_inv_op); else passed++;
        step();
        total++; if (tlb_inv_valid !== 1'b0) $display("FAIL inv5_pulse got=%0b exp=0", tlb_inv_valid); else passed++;
        total++; if (resp_err !== 1'b0) $display("FAIL inv5_err got=%0b exp=0", resp_err); else passed++;
        drain();
        req_inv_op = 7;
        send(3'd4);
        total++; if ({tlb_inv_valid, tlb_we} !== 2'b00) $display("FAIL inv7_strobes got=%0b%0b exp=00", tlb_inv_valid, tlb_we); else passed++;
        step();
        total++; if (resp_err !== 1'b1) $display("FAIL inv7_err got=%0b exp=1", resp_err); else passed++;
        drain();
    endtask

    task automatic test_reset_abort();
        send(3'd2);
        resetn = 1'b0;
        step();
        total++; if (tlb_we !== 1'b0) $display("FAIL abort_we got=%0b exp=0", tlb_we); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL abort_ready got=%0b exp=1", req_ready); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL abort_resp got=%0b exp=0", resp_valid); else passed++;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_resp_hold();
        tlb_s_found = 1; tlb_s_index = 11;
        send(3'd0);
        step();
        req_valid = 1'b1; req_op = 3'd2;  // must be ignored outside IDLE
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (resp_valid !== 1'b1 || resp_idx !== 4'd11 || resp_ne !== 1'b0 || resp_op !== 3'd0 || tlb_we !== 1'b0 || req_ready !== 1'b0)
                $display("FAIL hold_c%0d got v=%0b idx=%0d ne=%0b op=%0d we=%0b rdy=%0b exp 1/11/0/0/0/0",
                         c, resp_valid, resp_idx, resp_ne, resp_op, tlb_we, req_ready);
            else passed++;
        end
        req_valid = 1'b0;
        drain();
        total++; if (req_ready !== 1'b1) $display("FAIL hold_release got=%0b exp=1", req_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        req_op = 3'd2; req_valid = 1'b1; resp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin step(); if (tlb_we) pulses++; end
        req_valid = 1'b0; resp_ready = 1'b0;
        total++; if (pulses != 3) $display("FAIL b2b_pulses got=%0d exp=3", pulses); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL b2b_idle got=%0b exp=1", req_ready); else passed++;
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [IW-1:0] idx, eidx;
        logic ne, eerr, ene;
        logic [26:0] e0, e1;
        logic [18:0] v, iv;
        logic [9:0] a, ia;
        logic [5:0] ps;
        logic [4:0] iop;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            scramble();
            idx = csr_idx; ne = csr_ne; e0 = csr_elo0; e1 = csr_elo1; v = csr_vppn; a = csr_asid; ps = csr_ps;
            iop = 5'($urandom_range(0, 9)); req_inv_op = iop; iv = req_inv_vppn; ia = req_inv_asid;
            tlb_s_found = 1'($urandom); tlb_s_index = IW'($urandom); tlb_r_e = 1'($urandom);
            tlb_r_g = 1'($urandom); tlb_r_vppn = 19'($urandom); tlb_r_ps = 6'($urandom);
            tlb_r_asid = 10'($urandom); tlb_r_lo0 = 26'($urandom); tlb_r_lo1 = 26'($urandom);
            send(op);
            total++;
            if (tlb_we !== 1'(op == 2 || op == 3) || tlb_inv_valid !== 1'(op == 4 && iop <= 6))
                $display("FAIL rnd_strobes n=%0d op=%0d got we=%0b inv=%0b", n, op, tlb_we, tlb_inv_valid);
            else passed++;
            if (op == 2 || op == 3) begin
                eidx = (op == 3) ? IW'(fp_at) : idx;
                total++;
                if (tlb_w_index !== eidx || tlb_w_e !== !ne || tlb_w_g !== (e0[6] & e1[6]) || tlb_w_ps !== ps ||
                    tlb_w_asid !== a || tlb_w_lo0 !== strip_g(e0) || tlb_w_lo1 !== strip_g(e1))
                    $display("FAIL rnd_write n=%0d got idx=%0d e=%0b g=%0b exp idx=%0d", n, tlb_w_index, tlb_w_e, tlb_w_g, eidx);
                else passed++;
            end
            if (op == 0 || op == 4) begin
                total++;
                if (tlb_s_vppn !== (op == 4 ? iv : v) || tlb_s_asid !== (op == 4 ? ia : a))
                    $display("FAIL rnd_search n=%0d got %0h/%0h", n, tlb_s_vppn, tlb_s_asid);
                else passed++;
            end
            step();
            eerr = (op > 4) || (op == 4 && iop > 6);
            eidx = (op == 0) ? (tlb_s_found ? tlb_s_index : idx) : (op == 3) ? IW'(fp_at) : idx;
            ene  = (op == 0) ? !tlb_s_found : !tlb_r_e;
            total++;
            if (resp_valid !== 1'b1 || resp_err !== eerr || resp_op !== op)
                $display("FAIL rnd_resp n=%0d got v=%0b err=%0b op=%0d exp 1/%0b/%0d", n, resp_valid, resp_err, resp_op, eerr, op);
            else passed++;
            if (op <= 3) begin
                total++; if (resp_idx !== eidx) $display("FAIL rnd_idx n=%0d got=%0d exp=%0d", n, resp_idx, eidx); else passed++;
            end
            if (op <= 1) begin
                total++; if (resp_ne !== ene) $display("FAIL rnd_ne n=%0d got=%0b exp=%0b", n, resp_ne, ene); else passed++;
            end
            if (op == 1) begin
                total++;
                if (resp_elo0 !== (tlb_r_e ? add_g(tlb_r_lo0, tlb_r_g) : 27'd0) ||
                    resp_asid !== (tlb_r_e ? tlb_r_asid : 10'd0) || resp_ps !== (tlb_r_e ? tlb_r_ps : 6'd0))
                    $display("FAIL rnd_rd_data n=%0d got elo0=%0h asid=%0h ps=%0h", n, resp_elo0, resp_asid, resp_ps);
                else passed++;
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_wr();
        test_srch();
        test_rd();
        test_fill_wrap();
        test_inv();
        test_reset_abort();
        test_resp_hold();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
